hilo_md_ctrl: RTL and testbench
===============================

HILO_MD_CTRL -- requirements
Module: hilo_md_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  in  1  EX-stage request to begin a mul/div op.
REQ-004 SHALL have ports: op  in  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have ports: src_a  in  32  multiplicand / dividend.
REQ-006 SHALL have ports: src_b  in  32  multiplier / divisor.
REQ-007 SHALL have ports: flush  in  1  cancel any operation in flight.
REQ-008 SHALL have ports: stallreq  out  1  pipeline stall request to the stall controller.
REQ-009 SHALL have ports: busy  out  1  operation in progress.
REQ-010 SHALL have ports: hilo_we  out  1  one-cycle write-enable pulse for the hi/lo register.
REQ-011 SHALL have ports: hi_o  out  32  high word / remainder.
REQ-012 SHALL have ports: lo_o  out  32  low word / quotient.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 In IDLE, start=1 and flush=0 SHALL capture op, |src_a|, |src_b| and operand signs; magnitudes are taken only for signed ops (mult, div).
REQ-015 From IDLE, start SHALL transition to MUL (op[1]=0) or DIV (op[1]=1), and the iteration counter SHALL load 0.
REQ-016 MUL SHALL run 32 iterations of shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator.
REQ-017 DIV SHALL run 32 iterations of restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-018 After iteration 31, MUL or DIV SHALL move to DONE; DONE SHALL return to IDLE on the next cycle.
REQ-019 Latency: start accepted at cycle T -> iterations T+1..T+32 -> hilo_we=1 at T+33 only.
REQ-020 stallreq SHALL be combinationally 1 in IDLE when start=1 and flush=0.
REQ-021 stallreq SHALL be 1 throughout MUL and DIV, and 0 in DONE, so that the requesting instruction advances with its result.
REQ-022 busy SHALL be 1 in MUL, DIV and DONE.
REQ-023 In DONE, hi_o/lo_o SHALL be updated with sign-fixed results.
REQ-024 mult sign fix: the 64-bit product SHALL be negated (two's complement) when operand signs differ.
REQ-025 div sign fix: the quotient SHALL be negated when signs differ; the remainder SHALL take the dividend's sign.
REQ-026 div/divu with src_b=0 SHALL skip iteration: IDLE->DONE directly, hilo_we at T+1, lo_o=32'hFFFF_FFFF, hi_o=src_a.
REQ-027 div 0x8000_0000 / 0xFFFF_FFFF SHALL give lo_o=0x8000_0000, hi_o=0.
REQ-028 hi_o/lo_o SHALL hold their value between hilo_we pulses.
REQ-029 start while busy=1 SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-030 flush=1 in any state SHALL force IDLE next cycle with no hilo_we and hi_o/lo_o unchanged.
REQ-031 flush=1 in the same cycle as start SHALL take priority: start is not accepted.
REQ-032 start SHALL be accepted in IDLE on the cycle immediately after DONE (back-to-back operation).

Reset
REQ-033 rst=1 SHALL force IDLE and clear counter, accumulator, hi_o, lo_o, hilo_we, busy and stallreq to 0.
REQ-034 rst SHALL have priority over flush and start, including mid-operation.

Verification
REQ-035 multu 0xFFFF_FFFF*2, start at T -> stallreq 1 at T..T+32, hilo_we at T+33, hi_o=1, lo_o=0xFFFF_FFFE.
REQ-036 mult -3*5 -> hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFF1.
REQ-037 div -7/2 -> lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF; divu 7/2 -> lo_o=3, hi_o=1.
REQ-038 divu 7/0 -> hilo_we at T+1, lo_o=0xFFFF_FFFF, hi_o=7.
REQ-039 flush at iteration 10 -> no hilo_we, busy=0 next cycle, prior hi_o/lo_o retained; a new start is then accepted.
REQ-040 rst at iteration 20 -> all outputs 0 next cycle; start while busy ignored (second op's operands never appear in the result).

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_md_ctrl
// Iterative multiply/divide unit feeding the hi/lo register of the pipeline.
// A request accepted in IDLE runs 32 shift-add (mult/multu) or restoring
// shift-subtract (div/divu) iterations. It then spends one DONE cycle in
// which the sign-corrected result is presented together with a hilo_we pulse.
// Signed operands are reduced to magnitudes on capture. The signs are kept
// aside and applied to the result on the way out.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   EX-stage request to begin an operation
//   op        in   2   00 mult, 01 multu, 10 div, 11 divu
//   src_a     in  32   multiplicand / dividend
//   src_b     in  32   multiplier / divisor
//   flush     in   1   cancel any operation in flight
//   stallreq  out  1   pipeline stall request
//   busy      out  1   operation in progress (MUL, DIV, DONE)
//   hilo_we   out  1   one-cycle write enable for hi/lo
//   hi_o      out 32   high word / remainder
//   lo_o      out 32   low word / quotient
// ---------------------------------------------------------------------------
module hilo_md_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return (~v) + 64'd1;
    endfunction

    // Magnitude of a word; only signed ops interpret bit 31 as a sign.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic use_sign);
        return (use_sign && v[31]) ? neg32(v) : v;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;
    logic [31:0] opnd_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        hilo_we_r;
    logic        busy_r;

    logic        signed_op_s;
    logic        in_sign_a_s;
    logic        in_sign_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        zero_div_s;
    logic        accept_s;
    logic        last_iter_s;
    logic        stall_raw_s;

    logic [32:0] mul_sum_s;
    logic [63:0] mul_step_s;
    logic        div_ge_s;
    logic [31:0] div_sub_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    // Request decode: operand signs/magnitudes and acceptance condition.
    always_comb begin
        signed_op_s = ~op[0];
        in_sign_a_s = signed_op_s & src_a[31];
        in_sign_b_s = signed_op_s & src_b[31];
        mag_a_s     = mag32(src_a, signed_op_s);
        mag_b_s     = mag32(src_b, signed_op_s);
        zero_div_s  = op[1] & (src_b == 32'd0);
        accept_s    = (state_r == ST_IDLE) & start & ~flush;
        last_iter_s = (cnt_r == 5'd31);
    end

    // One iteration of each algorithm plus sign correction of the outcome.
    // Multiply: the multiplier sits in acc[31:0] and is consumed LSB first
    // while partial sums accumulate in the upper half. Divide: the dividend
    // shifts out of acc[31:0] into the remainder half and quotient bits fill
    // in from the bottom. The remainder is below the divisor, so a successful
    // subtract always fits in 32 bits.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_step_s = {mul_sum_s, acc_r[31:1]};
        div_ge_s   = (acc_r[63:31] >= {1'b0, opnd_r});
        div_sub_s  = acc_r[62:31] - opnd_r;
        div_step_s = div_ge_s ? {div_sub_s, acc_r[30:0], 1'b1}
                              : {acc_r[62:0], 1'b0};
        prod_fix_s = (sign_a_r ^ sign_b_r) ? neg64(mul_step_s) : mul_step_s;
        quot_fix_s = (sign_a_r ^ sign_b_r) ? neg32(div_step_s[31:0]) : div_step_s[31:0];
        rem_fix_s  = sign_a_r ? neg32(div_step_s[63:32]) : div_step_s[63:32];
    end

    // Next-state and stall decode; flush abandons an operation immediately.
    always_comb begin
        state_next_s = state_r;
        stall_raw_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    stall_raw_s = 1'b1;
                    if (op[1] == 1'b0) begin
                        state_next_s = ST_MUL;
                    end else if (zero_div_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DIV;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                stall_raw_s = 1'b1;
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Stall is dropped in DONE so the requesting instruction leaves EX with
    // its result; it is held low while reset is asserted.
    assign stallreq = stall_raw_s & ~rst;
    assign busy     = busy_r;
    assign hilo_we  = hilo_we_r;
    assign hi_o     = hi_r;
    assign lo_o     = lo_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, counter and result registers. The result is loaded on the
    // edge entering DONE, so hi_o/lo_o are valid for the whole hilo_we cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 5'd0;
            acc_r     <= 64'd0;
            opnd_r    <= 32'd0;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            hilo_we_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            hilo_we_r <= 1'b0;
            busy_r    <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= 5'd0;
                        sign_a_r <= in_sign_a_s;
                        sign_b_r <= in_sign_b_s;
                        if (op[1]) begin
                            acc_r  <= {32'd0, mag_a_s};
                            opnd_r <= mag_b_s;
                        end else begin
                            acc_r  <= {32'd0, mag_b_s};
                            opnd_r <= mag_a_s;
                        end
                        // Divide by zero bypasses iteration entirely.
                        if (zero_div_s) begin
                            hi_r      <= src_a;
                            lo_r      <= 32'hFFFF_FFFF;
                            hilo_we_r <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (!flush) begin
                        acc_r <= mul_step_s;
                        cnt_r <= cnt_r + 5'd1;
                        if (last_iter_s) begin
                            hi_r      <= prod_fix_s[63:32];
                            lo_r      <= prod_fix_s[31:0];
                            hilo_we_r <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (!flush) begin
                        acc_r <= div_step_s;
                        cnt_r <= cnt_r + 5'd1;
                        if (last_iter_s) begin
                            hi_r      <= rem_fix_s;
                            lo_r      <= quot_fix_s;
                            hilo_we_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stallreq;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests_run    = 0;
    int tests_failed = 0;

    hilo_md_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stallreq (stallreq),
        .busy     (busy),
        .hilo_we  (hilo_we),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    // Directed cases: multu FFFFFFFF*2, mult -3*5, div -7/2, divu 7/2,
    // divu 7/0, div 80000000/FFFFFFFF, div -5/0.
    localparam logic [1:0]  D_OP  [7] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    localparam logic [31:0] D_A   [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7,
                                          32'd7, 32'h8000_0000, 32'hFFFF_FFFB};
    localparam logic [31:0] D_B   [7] = '{32'd2, 32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    localparam logic [31:0] D_HI  [7] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd7,
                                          32'd0, 32'hFFFF_FFFB};
    localparam logic [31:0] D_LO  [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd3,
                                          32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    localparam int          D_LAT [7] = '{33, 33, 33, 33, 1, 33, 1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        if (o == 2'b00) begin
            res = sa * sb;
        end else if (o == 2'b01) begin
            res = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    // Issue one request at the current cycle and follow it until hilo_we.
    // Returns at the falling edge of the hilo_we cycle. lat is the cycle
    // count from acceptance (-1 if it never came); stalls counts stallreq
    // cycles before that.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls,
                         output logic [31:0] got_hi, output logic [31:0] got_lo);
        lat    = -1;
        stalls = 0;
        got_hi = 32'd0;
        got_lo = 32'd0;
        op     = o;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        @(negedge clk);
        if (stallreq === 1'b1) stalls++;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) begin
                lat    = k;
                got_hi = hi_o;
                got_lo = lo_o;
                break;
            end
            if (stallreq === 1'b1) stalls++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        flush = 1'b0;
        op    = 2'b01;
        src_a = 32'd5;
        src_b = 32'd7;
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if ({stallreq, busy, hilo_we, hi_o, lo_o} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b %b %b %h %h, expected all zero",
                     stallreq, busy, hilo_we, hi_o, lo_o);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        int          lat;
        int          stalls;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        for (int i = 0; i < 7; i++) begin
            do_op(D_OP[i], D_A[i], D_B[i], lat, stalls, got_hi, got_lo);
            tests_run++;
            if (lat !== D_LAT[i]) begin
                tests_failed++;
                $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, D_LAT[i]);
            end
            tests_run++;
            if (stalls !== D_LAT[i]) begin
                tests_failed++;
                $display("FAIL directed%0d_stall_cycles: got %0d expected %0d", i, stalls, D_LAT[i]);
            end
            tests_run++;
            if ({got_hi, got_lo} !== {D_HI[i], D_LO[i]}) begin
                tests_failed++;
                $display("FAIL directed%0d_result: got %h_%h expected %h_%h",
                         i, got_hi, got_lo, D_HI[i], D_LO[i]);
            end
            tests_run++;
            if ({stallreq, busy} !== 2'b01) begin
                tests_failed++;
                $display("FAIL directed%0d_done_flags: got stall=%b busy=%b expected 0 1",
                         i, stallreq, busy);
            end
            tick();
            @(negedge clk);
            tests_run++;
            if ({hilo_we, busy, hi_o, lo_o} !== {2'b00, D_HI[i], D_LO[i]}) begin
                tests_failed++;
                $display("FAIL directed%0d_hold: got we=%b busy=%b %h_%h expected 0 0 %h_%h",
                         i, hilo_we, busy, hi_o, lo_o, D_HI[i], D_LO[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int          lat;
        int          stalls;
        int          exp_lat;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp_res = ref_hilo(o, a, b);
            exp_lat = (o[1] && (b == 32'd0)) ? 1 : 33;
            do_op(o, a, b, lat, stalls, got_hi, got_lo);
            tests_run++;
            if (lat !== exp_lat || stalls !== exp_lat) begin
                tests_failed++;
                $display("FAIL random%0d_timing: got lat=%0d stalls=%0d expected %0d",
                         i, lat, stalls, exp_lat);
            end
            tests_run++;
            if ({got_hi, got_lo} !== exp_res) begin
                tests_failed++;
                $display("FAIL random%0d_result op=%b a=%h b=%h: got %h_%h expected %h",
                         i, o, a, b, got_hi, got_lo, exp_res);
            end
            // Next request issues in the cycle right after DONE.
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          stalls;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        do_op(2'b01, 32'd3, 32'd4, lat, stalls, got_hi, got_lo);
        tests_run++;
        if ({got_hi, got_lo} !== 64'd12) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h_%h expected 0_c", got_hi, got_lo);
        end
        tick();
        do_op(2'b11, 32'd100, 32'd7, lat, stalls, got_hi, got_lo);
        tests_run++;
        if (lat !== 33 || {got_hi, got_lo} !== {32'd2, 32'd14}) begin
            tests_failed++;
            $display("FAIL b2b_second: got lat=%0d %h_%h expected 33 2_e", lat, got_hi, got_lo);
        end
        tick();
    endtask

    // Relies on hi/lo = 2/14 left by test_back_to_back.
    task automatic test_flush();
        int          lat;
        int          stalls;
        int          we_count;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        op    = 2'b00;
        src_a = $urandom;
        src_b = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hilo_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_cycle_we: got %b expected 0", hilo_we);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, hilo_we, stallreq, hi_o, lo_o} !== {3'b000, 32'd2, 32'd14}) begin
            tests_failed++;
            $display("FAIL flush_after: got busy=%b we=%b stall=%b %h_%h expected 0 0 0 2_e",
                     busy, hilo_we, stallreq, hi_o, lo_o);
        end
        we_count = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            @(negedge clk);
            if (hilo_we === 1'b1) we_count++;
        end
        tests_run++;
        if (we_count !== 0) begin
            tests_failed++;
            $display("FAIL flush_no_we: got %0d pulses expected 0", we_count);
        end
        tick();
        a       = $urandom;
        b       = 32'($urandom_range(1, 1000));
        exp_res = ref_hilo(2'b11, a, b);
        do_op(2'b11, a, b, lat, stalls, got_hi, got_lo);
        tests_run++;
        if (lat !== 33 || {got_hi, got_lo} !== exp_res) begin
            tests_failed++;
            $display("FAIL flush_restart: got lat=%0d %h_%h expected 33 %h",
                     lat, got_hi, got_lo, exp_res);
        end
        tick();
        // flush and start together: start must be ignored.
        op    = 2'b01;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (stallreq !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_start_stall: got %b expected 0", stallreq);
        end
        tick();
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_start_busy: got %b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_start_busy();
        int          lat;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [63:0] exp_res;
        a1      = $urandom;
        b1      = $urandom;
        exp_res = ref_hilo(2'b01, a1, b1);
        lat     = -1;
        got_hi  = 32'd0;
        got_lo  = 32'd0;
        op      = 2'b01;
        src_a   = a1;
        src_b   = b1;
        start   = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            start = (k >= 3 && k <= 8) ? 1'b1 : 1'b0;
            op    = 2'b10;
            src_a = ~a1;
            src_b = b1 ^ 32'h0F0F_0F0F;
            @(negedge clk);
            if (hilo_we === 1'b1) begin
                lat    = k;
                got_hi = hi_o;
                got_lo = lo_o;
                break;
            end
            tick();
        end
        start = 1'b0;
        tests_run++;
        if (lat !== 33 || {got_hi, got_lo} !== exp_res) begin
            tests_failed++;
            $display("FAIL start_while_busy: got lat=%0d %h_%h expected 33 %h",
                     lat, got_hi, got_lo, exp_res);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_while_busy_idle: got busy=%b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          stalls;
        int          we_count;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        op    = 2'b00;
        src_a = 32'hFFFF_FFF0;
        src_b = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({stallreq, busy, hilo_we, hi_o, lo_o} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got %b %b %b %h_%h expected all zero",
                     stallreq, busy, hilo_we, hi_o, lo_o);
        end
        we_count = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            @(negedge clk);
            if (hilo_we === 1'b1) we_count++;
        end
        tests_run++;
        if (we_count !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_we: got %0d pulses expected 0", we_count);
        end
        tick();
        do_op(2'b00, 32'hFFFF_FFF0, 32'd9, lat, stalls, got_hi, got_lo);
        tests_run++;
        if (lat !== 33 || {got_hi, got_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FF70}) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: got lat=%0d %h_%h expected 33 ffffffff_ffffff70",
                     lat, got_hi, got_lo);
        end
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
